// File: rtl/id_tokenizer.sv
// Identifier tokenizer: letter-led, digit-terminated runs; token reported 1 cycle after its delimiter.
// Held token waits for tok_ready; a token completing while one is held without tok_ready is dropped and flagged.
module id_tokenizer #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  input  logic             tok_ready,
  output logic             tok_valid,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALPHA = 2'd1,
    DIGIT = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] run_len;

  logic is_letter;
  logic is_digit;
  logic is_alnum;

  logic run_start;
  logic run_more;
  logic tok_done;
  logic tok_load;
  logic tok_drop;
  logic tok_take;

  always_comb begin
    is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                ((char >= 8'h61) && (char <= 8'h7A));
    is_digit  = (char >= 8'h30) && (char <= 8'h39);
    is_alnum  = is_letter || is_digit;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (char_valid) begin
      unique case (state)
        IDLE: begin
          if (is_letter)     state_nxt = ALPHA;
          else if (is_digit) state_nxt = BAD;
          else               state_nxt = IDLE;
        end
        ALPHA, DIGIT: begin
          if (is_letter)     state_nxt = ALPHA;
          else if (is_digit) state_nxt = DIGIT;
          else               state_nxt = IDLE;
        end
        BAD: begin
          if (is_alnum)      state_nxt = BAD;
          else               state_nxt = IDLE;
        end
        default:             state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    run_start = char_valid && is_alnum && (state == IDLE);
    run_more  = char_valid && is_alnum && (state != IDLE);
    tok_done  = char_valid && !is_alnum && (state == DIGIT);
    tok_take  = tok_valid && tok_ready;
    // A handshake on the same edge frees the register for the new token.
    tok_load  = tok_done && (!tok_valid || tok_ready);
    tok_drop  = tok_done && tok_valid && !tok_ready;
  end

  // Run length is left untouched on a delimiter; the next run reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_len <= '0;
    end else if (run_start) begin
      run_len <= LEN_ONE;
    end else if (run_more && (run_len != LEN_MAX)) begin
      run_len <= run_len + LEN_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_valid <= 1'b0;
      tok_len   <= '0;
      tok_count <= '0;
    end else if (tok_load) begin
      tok_valid <= 1'b1;
      tok_len   <= run_len;
      tok_count <= tok_count + CNT_ONE;
    end else if (tok_take) begin
      tok_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (tok_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_tokenizer.sv
// Scoreboarded bench for id_tokenizer: directed streams plus random traffic against a string-level model.
module tb_id_tokenizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic        char_valid;
  logic        tok_ready;
  logic        tok_valid;
  logic [7:0]  tok_len;
  logic [15:0] tok_count;
  logic        overflow;

  id_tokenizer #(.LEN_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .char       (char),
    .char_valid (char_valid),
    .tok_ready  (tok_ready),
    .tok_valid  (tok_valid),
    .tok_len    (tok_len),
    .tok_count  (tok_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the current run as raw characters, plus the consumer-side view.
  byte         run_q[$];
  int          exp_q[$];
  bit          m_held;
  logic [15:0] m_count;
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit f_letter(input byte c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic bit f_digit(input byte c);
    return (c >= 8'h30 && c <= 8'h39);
  endfunction

  task automatic model_clear();
    run_q.delete();
    exp_q.delete();
    m_held  = 1'b0;
    m_count = '0;
    m_ovf   = 1'b0;
  endtask

  // Effect of one clock edge given the inputs that were applied for it.
  task automatic model_edge(input byte c, input bit v, input bit r);
    bit done;
    int len;
    done = 1'b0;
    len  = 0;
    if (v) begin
      if (f_letter(c) || f_digit(c)) begin
        run_q.push_back(c);
      end else begin
        if (run_q.size() > 0 && f_letter(run_q[0]) && f_digit(run_q[run_q.size()-1])) begin
          done = 1'b1;
          len  = (run_q.size() > 255) ? 255 : run_q.size();
        end
        run_q.delete();
      end
    end
    if (done) begin
      if (m_held && !r) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back(len);
        m_count = m_count + 16'd1;
        m_held  = 1'b1;
      end
    end else if (m_held && r) begin
      m_held = 1'b0;
    end
  endtask

  task automatic step(input byte c, input bit v, input bit r);
    char       = c;
    char_valid = v;
    tok_ready  = r;
    @(posedge clk);
    #1;
    model_edge(c, v, r);
    char_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, r);
  endtask

  task automatic send(input string s, input bit r);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, r);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    char_valid = 1'b0;
    tok_ready  = 1'b0;
    model_clear();
    #1;
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_tok_len",   tok_len,   0);
    chk("rst_tok_count", tok_count, 0);
    chk("rst_overflow",  overflow,  0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares registered outputs with the model and pops tokens on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      chk("mon_tok_valid", tok_valid, m_held);
      chk("mon_tok_count", tok_count, m_count);
      chk("mon_overflow",  overflow,  m_ovf);
      if (m_held && exp_q.size() > 0) chk("mon_tok_len_held", tok_len, exp_q[0]);
      if (tok_valid && tok_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got tok_len %0d expected no token", tok_len);
        end else begin
          chk("mon_tok_len_pop", tok_len, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    byte c;
    int  pick;
    reset      = 1'b1;
    char       = 8'h00;
    char_valid = 1'b0;
    tok_ready  = 1'b0;
    model_clear();
    #2;
    chk("init_tok_valid", tok_valid, 0);
    chk("init_tok_len",   tok_len,   0);
    chk("init_tok_count", tok_count, 0);
    chk("init_overflow",  overflow,  0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic identifier, one cycle after the delimiter
    send("ab12 ", 1'b1);
    chk("ab12_valid", tok_valid, 1);
    chk("ab12_len",   tok_len,   4);
    chk("ab12_count", tok_count, 1);
    idle(1, 1'b1);
    chk("ab12_cleared", tok_valid, 0);

    // Non-tokens
    do_reset();
    send("1ab2 ", 1'b1);
    send("ab ", 1'b1);
    send("a1b ", 1'b1);
    idle(2, 1'b1);
    chk("nontok_valid", tok_valid, 0);
    chk("nontok_count", tok_count, 0);

    // Drop while held
    do_reset();
    send("x1 y2 ", 1'b0);
    chk("drop_valid", tok_valid, 1);
    chk("drop_len",   tok_len,   2);
    chk("drop_count", tok_count, 1);
    chk("drop_ovf",   overflow,  1);
    idle(1, 1'b1);
    chk("drop_cleared", tok_valid, 0);
    chk("drop_ovf_sticky", overflow, 1);

    // Load on the same edge as a handshake
    do_reset();
    send("ab3 ", 1'b0);
    send("z9", 1'b0);
    step(" ", 1'b1, 1'b1);
    chk("hs_valid", tok_valid, 1);
    chk("hs_len",   tok_len,   2);
    chk("hs_count", tok_count, 2);
    chk("hs_ovf",   overflow,  0);
    idle(1, 1'b1);

    // Length saturation and char_valid gaps
    do_reset();
    for (int i = 0; i < 300; i++) step("q", 1'b1, 1'b1);
    send("7 ", 1'b1);
    chk("sat_len", tok_len, 255);
    idle(1, 1'b1);
    step("a", 1'b1, 1'b1);
    idle(3, 1'b1);
    step("5", 1'b1, 1'b1);
    idle(3, 1'b1);
    step(" ", 1'b1, 1'b1);
    chk("gap_len",   tok_len,   2);
    chk("gap_valid", tok_valid, 1);
    idle(1, 1'b1);

    // Reset mid-run discards the partial run
    do_reset();
    send("ab1", 1'b1);
    do_reset();
    send(" ", 1'b1);
    idle(2, 1'b1);
    chk("midrst_valid", tok_valid, 0);
    chk("midrst_len",   tok_len,   0);
    chk("midrst_count", tok_count, 0);
    chk("midrst_ovf",   overflow,  0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 3)      c = byte'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + $urandom_range(0, 25));
      else if (pick <= 6) c = byte'(8'h30 + $urandom_range(0, 9));
      else if (pick == 7) c = 8'h20;
      else if (pick == 8) c = byte'($urandom_range(0, 255));
      else                c = 8'h5F;
      step(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
    end
    step(" ", 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
